// File: rtl/istream_buffer_par.sv
// Instruction stream buffer: queues fetch blocks and splits them into up to DEQ_WAYS
// RVC/32-bit instructions per cycle. Define ISTREAM_BUFFER_PERF_EN to add perf counters.
module istream_buffer_par #(
  parameter int FETCH_PARCELS = 8,
  parameter int DEPTH         = 4,
  parameter int DEQ_WAYS      = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           enq_valid,
  input  logic [FETCH_PARCELS-1:0][15:0] enq_parcels,
  input  logic [FETCH_PARCELS-1:0]       enq_valid_mask,
  input  logic [31:0]                    enq_PC,
  input  logic                           enq_page_fault,
  input  logic                           enq_access_fault,
  output logic                           enq_ready,
  output logic [DEQ_WAYS-1:0]            deq_valid_by_way,
  output logic [DEQ_WAYS-1:0][31:0]      deq_instr_by_way,
  output logic [DEQ_WAYS-1:0][31:0]      deq_PC_by_way,
  output logic [DEQ_WAYS-1:0]            deq_uncompressed_by_way,
  output logic [DEQ_WAYS-1:0]            deq_page_fault_by_way,
  output logic [DEQ_WAYS-1:0]            deq_access_fault_by_way,
  output logic [DEQ_WAYS-1:0]            deq_straddle_err_by_way,
  input  logic                           deq_ready,
  input  logic                           flush_valid
`ifdef ISTREAM_BUFFER_PERF_EN
  ,
  output logic [31:0]                    perf_full_cycles,
  output logic [31:0]                    perf_starve_cycles
`endif
);
  localparam int PIW = $clog2(FETCH_PARCELS);
  localparam int PW  = PIW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  logic [FETCH_PARCELS-1:0][15:0] mem_parcels [DEPTH];
  logic [FETCH_PARCELS-1:0]       mem_mask    [DEPTH];
  logic [31:0]                    mem_pc      [DEPTH];
  logic [DEPTH-1:0]               mem_pf;
  logic [DEPTH-1:0]               mem_af;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_next;
  logic [CW-1:0] count;
  logic [PW-1:0] offset;
  logic [1:0]    n_avail;
  logic          enq_fire;
  logic          deq_fire;
  logic          any_valid;

  // Views of the head and head+1 blocks; index 0 is the head
  logic [FETCH_PARCELS-1:0][15:0] b_par  [2];
  logic [31:0]                    b_pc   [2];
  logic [PW-1:0]                  b_fv   [2];
  logic [PW-1:0]                  b_lv   [2];
  logic [1:0]                     b_pf;
  logic [1:0]                     b_af;
  logic [1:0]                     b_flt;

  logic [1:0]                     w_blk;
  logic [PW-1:0]                  w_pos;
  logic [PW-1:0]                  w_eff;
  logic [PW-1:0]                  w_fv;
  logic [PW-1:0]                  w_lv;
  logic                           w_stop;
  logic                           w_sel;
  logic [15:0]                    w_lo;
  logic [FETCH_PARCELS-1:0][15:0] w_par;
  logic [1:0]                     deq_freed;
  logic [PW-1:0]                  deq_off;

  function automatic logic [PW-1:0] first_valid(input logic [FETCH_PARCELS-1:0] m);
    first_valid = PW'(FETCH_PARCELS);
    for (int i = FETCH_PARCELS - 1; i >= 0; i--)
      if (m[i]) first_valid = PW'(i);
  endfunction

  function automatic logic [PW-1:0] last_valid(input logic [FETCH_PARCELS-1:0] m);
    last_valid = '0;
    for (int i = 0; i < FETCH_PARCELS; i++)
      if (m[i]) last_valid = PW'(i);
  endfunction

  function automatic logic [PW-1:0] eff_pos(input logic [PW-1:0] pos, input logic [PW-1:0] fv);
    eff_pos = (pos < fv) ? fv : pos;
  endfunction

  assign head_next = head + AW'(1);
  assign enq_ready = (count < CW'(DEPTH));
  assign n_avail   = (count >= CW'(2)) ? 2'd2 : count[1:0];
  assign enq_fire  = enq_valid & enq_ready & ~flush_valid;
  assign any_valid = deq_valid_by_way[0];
  assign deq_fire  = deq_ready & any_valid & ~flush_valid;

  always_comb begin
    b_par[0] = mem_parcels[head];
    b_par[1] = mem_parcels[head_next];
    b_pc[0]  = mem_pc[head];
    b_pc[1]  = mem_pc[head_next];
    b_fv[0]  = first_valid(mem_mask[head]);
    b_fv[1]  = first_valid(mem_mask[head_next]);
    b_lv[0]  = last_valid(mem_mask[head]);
    b_lv[1]  = last_valid(mem_mask[head_next]);
    b_pf     = {mem_pf[head_next], mem_pf[head]};
    b_af     = {mem_af[head_next], mem_af[head]};
    b_flt    = b_pf | b_af;
  end

  // Walk parcels across head/head+1, emitting one instruction per way until blocked
  always_comb begin
    deq_valid_by_way        = '0;
    deq_instr_by_way        = '0;
    deq_PC_by_way           = '0;
    deq_uncompressed_by_way = '0;
    deq_page_fault_by_way   = '0;
    deq_access_fault_by_way = '0;
    deq_straddle_err_by_way = '0;
    w_blk  = 2'd0;
    w_pos  = offset;
    w_stop = 1'b0;
    w_sel  = 1'b0;
    w_eff  = '0;
    w_fv   = '0;
    w_lv   = '0;
    w_lo   = '0;
    w_par  = '0;
    for (int w = 0; w < DEQ_WAYS; w++) begin
      for (int k = 0; k < 2; k++) begin
        if (!w_stop && w_blk == 2'(k) && 2'(k) < n_avail && !b_flt[k] &&
            eff_pos(w_pos, b_fv[k]) > b_lv[k]) begin
          w_blk = 2'(k + 1);
          w_pos = '0;
        end
      end
      if (!w_stop && w_blk < n_avail) begin
        w_sel = w_blk[0];
        w_par = b_par[w_sel];
        w_fv  = b_fv[w_sel];
        w_lv  = b_lv[w_sel];
        w_eff = eff_pos(w_pos, w_fv);
        w_lo  = w_par[w_eff[PIW-1:0]];
        if (b_flt[w_sel]) begin
          deq_valid_by_way[w]        = 1'b1;
          deq_page_fault_by_way[w]   = b_pf[w_sel];
          deq_access_fault_by_way[w] = b_af[w_sel];
          deq_PC_by_way[w]           = b_pc[w_sel] + (32'(w_fv) << 1);
          w_blk  = w_blk + 2'd1;
          w_pos  = '0;
          w_stop = 1'b1;
        end else begin
          deq_PC_by_way[w] = b_pc[w_sel] + (32'(w_eff) << 1);
          if (w_lo[1:0] != 2'b11) begin
            deq_valid_by_way[w] = 1'b1;
            deq_instr_by_way[w] = {16'h0000, w_lo};
            w_pos = w_eff + PW'(1);
          end else if (w_eff < w_lv) begin
            deq_valid_by_way[w]        = 1'b1;
            deq_instr_by_way[w]        = {w_par[PIW'(w_eff + PW'(1))], w_lo};
            deq_uncompressed_by_way[w] = 1'b1;
            w_pos = w_eff + PW'(2);
          end else if (w_eff == PW'(FETCH_PARCELS - 1)) begin
            // Upper half comes from the next block; its fetch faults taint the instruction
            if (w_blk == 2'd0 && n_avail == 2'd2) begin
              deq_valid_by_way[w]        = 1'b1;
              deq_instr_by_way[w]        = {b_par[1][b_fv[1][PIW-1:0]], w_lo};
              deq_uncompressed_by_way[w] = 1'b1;
              deq_page_fault_by_way[w]   = b_pf[1];
              deq_access_fault_by_way[w] = b_af[1];
              if (b_flt[1]) begin
                w_blk  = 2'd2;
                w_pos  = '0;
                w_stop = 1'b1;
              end else begin
                w_blk = 2'd1;
                w_pos = b_fv[1] + PW'(1);
              end
            end else begin
              w_stop = 1'b1;
            end
          end else begin
            deq_valid_by_way[w]        = 1'b1;
            deq_instr_by_way[w]        = {16'h0000, w_lo};
            deq_uncompressed_by_way[w] = 1'b1;
            deq_straddle_err_by_way[w] = 1'b1;
            w_pos = w_eff + PW'(1);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (!w_stop && w_blk == 2'(k) && 2'(k) < n_avail && !b_flt[k] &&
          eff_pos(w_pos, b_fv[k]) > b_lv[k]) begin
        w_blk = 2'(k + 1);
        w_pos = '0;
      end
    end
    deq_freed = w_blk;
    deq_off   = w_pos;
  end

  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      mem_parcels[tail] <= enq_parcels;
      mem_mask[tail]    <= enq_valid_mask;
      mem_pc[tail]      <= enq_PC;
      mem_pf[tail]      <= enq_page_fault;
      mem_af[tail]      <= enq_access_fault;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      offset <= '0;
    end else if (flush_valid) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      offset <= '0;
    end else begin
      if (enq_fire) tail <= tail + AW'(1);
      if (deq_fire) begin
        head   <= head + AW'(deq_freed);
        offset <= deq_off;
      end
      count <= count + CW'(enq_fire) - (deq_fire ? CW'(deq_freed) : CW'(0));
    end
  end

`ifdef ISTREAM_BUFFER_PERF_EN
  // Saturating stall counters; flush deliberately leaves them alone
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_full_cycles   <= '0;
      perf_starve_cycles <= '0;
    end else begin
      if (enq_valid && !enq_ready && perf_full_cycles != 32'hFFFF_FFFF)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (deq_ready && !any_valid && perf_starve_cycles != 32'hFFFF_FFFF)
        perf_starve_cycles <= perf_starve_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_istream_buffer_par.sv
// Testbench for istream_buffer_par: directed scenarios plus randomized traffic checked
// against a queue-based model of the instruction stream.
module tb_istream_buffer_par;
  localparam int FP    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 enq_valid;
  logic [FP-1:0][15:0]  enq_parcels;
  logic [FP-1:0]        enq_valid_mask;
  logic [31:0]          enq_PC;
  logic                 enq_page_fault;
  logic                 enq_access_fault;
  logic                 enq_ready;
  logic [DW-1:0]        deq_valid_by_way;
  logic [DW-1:0][31:0]  deq_instr_by_way;
  logic [DW-1:0][31:0]  deq_PC_by_way;
  logic [DW-1:0]        deq_uncompressed_by_way;
  logic [DW-1:0]        deq_page_fault_by_way;
  logic [DW-1:0]        deq_access_fault_by_way;
  logic [DW-1:0]        deq_straddle_err_by_way;
  logic                 deq_ready;
  logic                 flush_valid;

  istream_buffer_par #(.FETCH_PARCELS(FP), .DEPTH(DEPTH), .DEQ_WAYS(DW)) dut (
    .CLK(CLK), .RST(RST),
    .enq_valid(enq_valid), .enq_parcels(enq_parcels), .enq_valid_mask(enq_valid_mask),
    .enq_PC(enq_PC), .enq_page_fault(enq_page_fault), .enq_access_fault(enq_access_fault),
    .enq_ready(enq_ready),
    .deq_valid_by_way(deq_valid_by_way), .deq_instr_by_way(deq_instr_by_way),
    .deq_PC_by_way(deq_PC_by_way), .deq_uncompressed_by_way(deq_uncompressed_by_way),
    .deq_page_fault_by_way(deq_page_fault_by_way),
    .deq_access_fault_by_way(deq_access_fault_by_way),
    .deq_straddle_err_by_way(deq_straddle_err_by_way),
    .deq_ready(deq_ready), .flush_valid(flush_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [FP-1:0][15:0] par;
    logic [FP-1:0]       mask;
    logic [31:0]         pc;
    logic                pf;
    logic                af;
  } blk_t;

  blk_t        q[$];
  int          off;
  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] e_valid, e_unc, e_pf, e_af, e_se;
  logic [31:0] e_instr [DW];
  logic [31:0] e_pc    [DW];
  int          e_freed;
  int          e_off;
  blk_t        idle_blk = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int first_v(input logic [FP-1:0] m);
    for (int i = 0; i < FP; i++) if (m[i]) return i;
    return FP;
  endfunction

  function automatic int last_v(input logic [FP-1:0] m);
    for (int i = FP - 1; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  function automatic bit exhausted(input int b, input int p);
    if (b >= 2 || b >= q.size()) return 0;
    if (q[b].pf || q[b].af) return 0;
    return ((p > first_v(q[b].mask)) ? p : first_v(q[b].mask)) > last_v(q[b].mask);
  endfunction

  // Expected presentation of the current queue contents, plus what a dequeue would free
  task automatic model_present();
    int b, p, e, f, l;
    bit stop;
    blk_t cb, nb;
    logic [15:0] lo;
    b = 0; p = off; stop = 0;
    e_valid = '0; e_unc = '0; e_pf = '0; e_af = '0; e_se = '0;
    for (int w = 0; w < DW; w++) begin e_instr[w] = 0; e_pc[w] = 0; end
    for (int w = 0; w < DW; w++) begin
      while (!stop && exhausted(b, p)) begin b++; p = 0; end
      if (stop || b >= 2 || b >= q.size()) break;
      cb = q[b]; f = first_v(cb.mask); l = last_v(cb.mask);
      e = (p > f) ? p : f;
      if (cb.pf || cb.af) begin
        e_valid[w] = 1; e_pf[w] = cb.pf; e_af[w] = cb.af; e_pc[w] = cb.pc + 32'(2 * f);
        b++; p = 0; stop = 1;
      end else begin
        lo = cb.par[e];
        e_pc[w] = cb.pc + 32'(2 * e);
        if (lo[1:0] != 2'b11) begin
          e_valid[w] = 1; e_instr[w] = {16'h0, lo}; p = e + 1;
        end else if (e < l) begin
          e_valid[w] = 1; e_instr[w] = {cb.par[e+1], lo}; e_unc[w] = 1; p = e + 2;
        end else if (e == FP - 1) begin
          if (b == 0 && q.size() >= 2) begin
            nb = q[1]; f = first_v(nb.mask);
            e_valid[w] = 1; e_instr[w] = {nb.par[f], lo}; e_unc[w] = 1;
            e_pf[w] = nb.pf; e_af[w] = nb.af;
            if (nb.pf || nb.af) begin b = 2; p = 0; stop = 1; end
            else begin b = 1; p = f + 1; end
          end else stop = 1;
        end else begin
          e_valid[w] = 1; e_instr[w] = {16'h0, lo}; e_unc[w] = 1; e_se[w] = 1; p = e + 1;
        end
      end
    end
    while (!stop && exhausted(b, p)) begin b++; p = 0; end
    e_freed = b; e_off = p;
  endtask

  task automatic check_output();
    model_present();
    check("enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
    check("valid", 32'(deq_valid_by_way), 32'(e_valid));
    for (int w = 0; w < DW; w++) begin
      if (e_valid[w]) begin
        check($sformatf("instr%0d", w), deq_instr_by_way[w], e_instr[w]);
        check($sformatf("pc%0d", w), deq_PC_by_way[w], e_pc[w]);
        check($sformatf("unc%0d", w), 32'(deq_uncompressed_by_way[w]), 32'(e_unc[w]));
        check($sformatf("pf%0d", w), 32'(deq_page_fault_by_way[w]), 32'(e_pf[w]));
        check($sformatf("af%0d", w), 32'(deq_access_fault_by_way[w]), 32'(e_af[w]));
        check($sformatf("se%0d", w), 32'(deq_straddle_err_by_way[w]), 32'(e_se[w]));
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare at edge+1
  task automatic apply_stimulus(input bit ev, input blk_t nb, input bit dr, input bit fl);
    bit fire;
    enq_valid = ev; enq_parcels = nb.par; enq_valid_mask = nb.mask; enq_PC = nb.pc;
    enq_page_fault = nb.pf; enq_access_fault = nb.af; deq_ready = dr; flush_valid = fl;
    model_present();
    fire = ev && (q.size() < DEPTH) && !fl;
    if (fl) begin
      q.delete(); off = 0;
    end else begin
      if (dr && e_valid[0]) begin
        repeat (e_freed) void'(q.pop_front());
        off = e_off;
      end
      if (fire) q.push_back(nb);
    end
    @(posedge CLK); #1;
    enq_valid = 0; deq_ready = 0; flush_valid = 0;
    check_output();
  endtask

  function automatic blk_t mk_blk(input logic [31:0] pc, input logic [FP-1:0] mask, input logic pf);
    blk_t b;
    b.pc = pc; b.mask = mask; b.pf = pf; b.af = 1'b0;
    for (int i = 0; i < FP; i++) b.par[i] = 16'hA000 | 16'(i << 4);
    return b;
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    int lo, hi;
    lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FP - 1)) : 0;
    hi = ($urandom_range(0, 1) == 1) ? FP - 1 : int'($urandom_range(lo, FP - 1));
    b.mask = '0;
    for (int i = lo; i <= hi; i++) b.mask[i] = 1'b1;
    b.pc = $urandom() & 32'hFFFF_FFF0;
    for (int i = 0; i < FP; i++) begin
      b.par[i] = 16'($urandom());
      b.par[i][1:0] = ($urandom_range(0, 4) < 2) ? 2'b11 : 2'($urandom_range(0, 2));
    end
    b.pf = ($urandom_range(0, 15) == 0);
    b.af = ($urandom_range(0, 15) == 0);
    return b;
  endfunction

  initial begin
    blk_t a, b;
    RST = 1; enq_valid = 0; enq_parcels = '0; enq_valid_mask = '0; enq_PC = '0;
    enq_page_fault = 0; enq_access_fault = 0; deq_ready = 0; flush_valid = 0;
    q.delete(); off = 0;
    #2;
    check("rst_ready", 32'(enq_ready), 32'd1);
    check("rst_valid", 32'(deq_valid_by_way), 32'd0);
    check("rst_instr0", deq_instr_by_way[0], 32'd0);
    check("rst_pc0", deq_PC_by_way[0], 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
    check_output();

    // Plain 16-bit block, two dequeues drain it
    apply_stimulus(1, mk_blk(32'h1000, 8'hFF, 0), 0, 0);
    check("r031_valid", 32'(deq_valid_by_way), 32'hF);
    check("r031_pc0", deq_PC_by_way[0], 32'h1000);
    check("r031_pc3", deq_PC_by_way[3], 32'h1006);
    apply_stimulus(0, idle_blk, 1, 0);
    check("r031_pc4", deq_PC_by_way[0], 32'h1008);
    check("r031_pc7", deq_PC_by_way[3], 32'h100E);
    apply_stimulus(0, idle_blk, 1, 0);
    check("r031_freed", 32'(deq_valid_by_way), 32'h0);

    // 32-bit instruction straddling into a late-arriving block
    a = mk_blk(32'h2000, 8'hFF, 0); a.par[7] = 16'h1233;
    b = mk_blk(32'h2010, 8'hFF, 0); b.par[0] = 16'h4440;
    apply_stimulus(1, a, 0, 0);
    apply_stimulus(0, idle_blk, 1, 0);
    check("r032_wait3", 32'(deq_valid_by_way), 32'h7);
    apply_stimulus(0, idle_blk, 1, 0);
    check("r032_wait0", 32'(deq_valid_by_way), 32'h0);
    apply_stimulus(0, idle_blk, 0, 0);
    apply_stimulus(1, b, 0, 0);
    check("r032_instr", deq_instr_by_way[0], 32'h4440_1233);
    check("r032_pc", deq_PC_by_way[0], 32'h200E);
    check("r032_unc", 32'(deq_uncompressed_by_way[0]), 32'd1);
    repeat (4) apply_stimulus(0, idle_blk, 1, 0);

    // Fill to full, free one block, then flush with enq and deq in the same cycle
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, mk_blk(32'h5000 + 32'(i * 16), 8'hF0, 0), 0, 0);
    check("r033_full", 32'(enq_ready), 32'd0);
    apply_stimulus(0, idle_blk, 1, 0);
    check("r033_ready", 32'(enq_ready), 32'd1);
    apply_stimulus(1, mk_blk(32'h6000, 8'hFF, 0), 1, 1);
    check("r036_valid", 32'(deq_valid_by_way), 32'd0);
    check("r036_ready", 32'(enq_ready), 32'd1);

    // 32-bit start on the last valid parcel of a partial block
    a = mk_blk(32'h3000, 8'h0F, 0); a.par[3] = 16'h7777;
    apply_stimulus(1, a, 0, 0);
    check("r034_se", 32'(deq_straddle_err_by_way[3]), 32'd1);
    check("r034_pc", deq_PC_by_way[3], 32'h3006);
    check("r034_instr", deq_instr_by_way[3], 32'h0000_7777);
    apply_stimulus(0, idle_blk, 1, 0);

    // Faulting block behind two 16-bit instructions
    apply_stimulus(1, mk_blk(32'h4000, 8'h03, 0), 0, 0);
    apply_stimulus(1, mk_blk(32'h4010, 8'hFF, 1), 0, 0);
    check("r035_valid", 32'(deq_valid_by_way), 32'h7);
    check("r035_pf2", 32'(deq_page_fault_by_way[2]), 32'd1);
    check("r035_pc2", deq_PC_by_way[2], 32'h4010);
    apply_stimulus(0, idle_blk, 1, 0);

    // Asynchronous reset in the middle of a cycle
    apply_stimulus(1, rnd_blk(), 0, 0);
    apply_stimulus(1, mk_blk(32'h7000, 8'hFF, 0), 0, 0);
    #3 RST = 1;
    #1;
    check("arst_valid", 32'(deq_valid_by_way), 32'd0);
    check("arst_ready", 32'(enq_ready), 32'd1);
    @(negedge CLK); RST = 0;
    q.delete(); off = 0;
    @(posedge CLK); #1;
    check_output();

    for (int i = 0; i < 800; i++)
      apply_stimulus($urandom_range(0, 3) != 0, rnd_blk(), $urandom_range(0, 2) != 0,
                     $urandom_range(0, 39) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/istream_buffer_par.md
ISTREAM_BUFFER_PAR -- requirements
Module: istream_buffer_par

Interface
REQ-001 SHALL have parameter FETCH_PARCELS, default 8, meaning 16-bit parcels per enqueued fetch block (16B); power of 2, >=4.
REQ-002 SHALL have parameter DEPTH, default 4, meaning fetch-block entries; power of 2, >=2.
REQ-003 SHALL have parameter DEQ_WAYS, default 4, meaning instructions presented per cycle; DEQ_WAYS <= FETCH_PARCELS/2.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enq_valid  input  1  fetch block offered.
REQ-007 SHALL have port enq_parcels  input  FETCH_PARCELS x 16  block data, parcel i at byte offset 2i.
REQ-008 SHALL have port enq_valid_mask  input  FETCH_PARCELS  contiguous run of valid parcels.
REQ-009 SHALL have port enq_PC  input  32  block-aligned VA of parcel 0.
REQ-010 SHALL have port enq_page_fault / enq_access_fault  input  1 each  fetch exception for block.
REQ-011 SHALL have port enq_ready  output  1  block accepted when enq_valid & enq_ready.
REQ-012 SHALL have port deq_valid_by_way  output  DEQ_WAYS  way holds instruction; contiguous from way 0.
REQ-013 SHALL have ports deq_instr_by_way (DEQ_WAYS x 32), deq_PC_by_way (DEQ_WAYS x 32), deq_uncompressed_by_way, deq_page_fault_by_way, deq_access_fault_by_way, deq_straddle_err_by_way (DEQ_WAYS each)  output.
REQ-014 SHALL have port deq_ready  input  1  consumer takes all valid ways this cycle.
REQ-015 SHALL have port flush_valid  input  1  discard all contents (restart).

Function
REQ-016 SHALL store blocks in a DEPTH-entry circular buffer with head/tail pointers plus a parcel offset into the head block; pointers wrap modulo DEPTH.
REQ-017 SHALL assert enq_ready iff registered block count < DEPTH; no same-cycle full bypass.
REQ-018 SHALL make an enqueued block visible on deq outputs the cycle after acceptance (1-cycle latency).
REQ-019 SHALL decode boundaries from head and head+1 blocks only: parcel with bits[1:0]==2'b11 starts 32-bit instruction, otherwise 16-bit (upper 16 bits output zero, uncompressed=0).
REQ-020 SHALL form a 32-bit instruction straddling blocks from the head block's last parcel and head+1's first valid parcel when head block's parcel FETCH_PARCELS-1 is valid; if head+1 absent, that way and later ways SHALL be invalid.
REQ-021 SHALL, when a 32-bit instruction starts on a block's last valid parcel and that parcel is not FETCH_PARCELS-1, emit it with upper half zero, uncompressed=1, straddle_err=1, consuming one parcel.
REQ-022 SHALL set deq_PC = block enq_PC + 2*parcel index of the instruction's first parcel.
REQ-023 SHALL present a faulting block as one way with fault flags set, instr 0, PC of its first valid parcel, consuming the whole block; ways after it invalid that cycle.
REQ-024 SHALL, on deq_ready with >=1 valid way, advance offset past all presented parcels and free each fully consumed block (0, 1 or 2 per cycle); deq_ready with no valid way SHALL be a no-op.
REQ-025 SHALL, on simultaneous enq accept and deq consume, apply both; count updates by +1 minus freed blocks.
REQ-026 SHALL, on flush_valid, empty the buffer next cycle, dropping any same-cycle enq and ignoring same-cycle deq_ready.

Reset
REQ-027 SHALL, while RST high, clear pointers, offset and count; enq_ready=1, deq_valid_by_way=0, all other deq outputs 0.
REQ-028 SHALL treat reset asserted mid-operation as immediate discard of contents, asynchronously.

Configuration
REQ-029 SHALL, with ISTREAM_BUFFER_PERF_EN defined, add outputs perf_full_cycles and perf_starve_cycles (32 each), saturating at 2^32-1, counting cycles with enq_valid & !enq_ready and deq_ready & no valid way; cleared by RST, not by flush.
REQ-030 SHALL, without ISTREAM_BUFFER_PERF_EN, omit those ports and counters with otherwise identical behaviour.

Verification
REQ-031 SHALL cover: enq block PC 0x1000, all parcels 16-bit, mask 0xFF -> next cycle ways 0-3 valid, PCs 0x1000/02/04/06; after deq_ready, PCs 0x1008-0x100E; block freed.
REQ-032 SHALL cover: 32-bit instr at parcel 7 of block 0x2000, block 0x2010 enqueued 3 cycles later -> way invalid until then, then instr {p0', p7}, PC 0x200E, uncompressed=1.
REQ-033 SHALL cover: fill 4 blocks with deq_ready=0 -> enq_ready=0; one deq freeing 1 block -> enq_ready=1 next cycle.
REQ-034 SHALL cover: enq mask 0x0F with 32-bit start at parcel 3 -> straddle_err=1, PC base+6.
REQ-035 SHALL cover: block with enq_page_fault=1 behind two 16-bit instrs -> ways 0-1 normal, way 2 page_fault=1, way 3 invalid.
REQ-036 SHALL cover: flush_valid with enq_valid and deq_ready same cycle -> next cycle deq_valid_by_way=0, enq_ready=1, nothing consumed downstream.
